// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common to the transmitter and
// receiver) and the default frame geometry.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int OVER_SAMPLE_DEF = 16;
    localparam int DATA_WIDTH_DEF  = 8;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for the asynchronous serial input. Both flops reset
// high so a reset never looks like a start bit.
module rx_sync (
    input  logic bclk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [1:0] sync_reg;

    // Shift the raw input through two flops toward the bclk domain.
    always_ff @(posedge bclk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], d};
        end
    end

    assign q = sync_reg[1];

endmodule

// File: rtl/receiver.sv
// UART receiver: validates the start bit at mid-bit, samples data LSB-first at
// the end of each bit period counted from that point, checks the stop bit and
// presents the word in a single-entry valid/ready holding register.
module receiver
    import uart_pkg::*;
#(
    parameter int over_sample = OVER_SAMPLE_DEF,
    parameter int data_width  = DATA_WIDTH_DEF,
    parameter int data_bits   = $clog2(data_width)
) (
    input  logic                  bclk,
    input  logic                  reset_n,
    input  logic                  rx,
    input  logic                  rx_ready,
    output logic [data_width-1:0] rx_dout,
    output logic                  rx_valid,
    output logic                  rx_done_tk,
    output logic                  frame_err,
    output logic                  overrun_err
);

    // Tick counter must hold over_sample-1 and is never narrower than 4 bits.
    localparam int TK_W = ($clog2(over_sample) < 4) ? 4 : $clog2(over_sample);
    localparam logic [TK_W-1:0]      TK_MID  = TK_W'(over_sample / 2 - 1);
    localparam logic [TK_W-1:0]      TK_LAST = TK_W'(over_sample - 1);
    localparam logic [data_bits-1:0] BC_LAST = data_bits'(data_width - 1);

    logic rx_s;

    uart_state_t           state_reg,  state_next;
    logic [TK_W-1:0]       tk_reg,     tk_next;
    logic [data_bits-1:0]  bc_reg,     bc_next;
    logic [data_width-1:0] shift_reg,  shift_next;
    logic [data_width-1:0] dout_reg,   dout_next;
    logic                  valid_reg,  valid_next;
    logic                  done_reg,   done_next;
    logic                  ferr_reg,   ferr_next;
    logic                  oerr_reg,   oerr_next;
    logic                  armed_reg,  armed_next;

    rx_sync u_rx_sync (
        .bclk    (bclk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    // State, counters, shift/holding registers and registered pulses.
    always_ff @(posedge bclk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            tk_reg    <= '0;
            bc_reg    <= '0;
            shift_reg <= '0;
            dout_reg  <= '0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
            ferr_reg  <= 1'b0;
            oerr_reg  <= 1'b0;
            armed_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            tk_reg    <= tk_next;
            bc_reg    <= bc_next;
            shift_reg <= shift_next;
            dout_reg  <= dout_next;
            valid_reg <= valid_next;
            done_reg  <= done_next;
            ferr_reg  <= ferr_next;
            oerr_reg  <= oerr_next;
            armed_reg <= armed_next;
        end
    end

    // Next-state logic: frame sequencing, sampling and holding-register handshake.
    always_comb begin
        state_next = state_reg;
        tk_next    = tk_reg;
        bc_next    = bc_reg;
        shift_next = shift_reg;
        dout_next  = dout_reg;
        valid_next = valid_reg;
        done_next  = 1'b0;
        ferr_next  = 1'b0;
        oerr_next  = 1'b0;
        // A high line re-arms start detection; a break keeps it disarmed.
        armed_next = armed_reg | rx_s;

        if (valid_reg && rx_ready) begin
            valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                tk_next = '0;
                if (armed_reg && !rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (tk_reg == TK_MID) begin
                    tk_next = '0;
                    if (!rx_s) begin
                        state_next = DATA;
                        bc_next    = '0;
                    end else begin
                        // Start bit did not survive to mid-bit: a glitch.
                        state_next = IDLE;
                    end
                end else begin
                    tk_next = tk_reg + 1'b1;
                end
            end
            DATA: begin
                if (tk_reg == TK_LAST) begin
                    tk_next    = '0;
                    shift_next = {rx_s, shift_reg[data_width-1:1]};
                    if (bc_reg == BC_LAST) begin
                        state_next = STOP;
                    end else begin
                        bc_next = bc_reg + 1'b1;
                    end
                end else begin
                    tk_next = tk_reg + 1'b1;
                end
            end
            STOP: begin
                if (tk_reg == TK_LAST) begin
                    tk_next    = '0;
                    state_next = IDLE;
                    if (rx_s) begin
                        done_next = 1'b1;
                        // Load if the register is empty or being drained this cycle.
                        if (!valid_reg || rx_ready) begin
                            dout_next  = shift_reg;
                            valid_next = 1'b1;
                        end else begin
                            oerr_next = 1'b1;
                        end
                    end else begin
                        ferr_next  = 1'b1;
                        armed_next = 1'b0;
                    end
                end else begin
                    tk_next = tk_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rx_dout     = dout_reg;
    assign rx_valid    = valid_reg;
    assign rx_done_tk  = done_reg;
    assign frame_err   = ferr_reg;
    assign overrun_err = oerr_reg;

endmodule

// File: tb/tb_receiver.sv
// Bench for the UART receiver. The driver serialises frames on rx and records
// when each stop bit must be judged; a transaction-level model of the holding
// register predicts every output on every cycle.
module tb_receiver;

    localparam int OS = 16;
    localparam int DW = 8;
    // Bench drives rx right after a falling edge; two synchroniser edges plus
    // one IDLE edge give T, and the stop sample lands at T + 152.
    localparam int STOP_LAT = 3 + OS / 2 + (DW + 1) * OS;

    logic          bclk     = 1'b0;
    logic          reset_n  = 1'b0;
    logic          rx       = 1'b1;
    logic          rx_ready = 1'b0;
    logic [DW-1:0] rx_dout;
    logic          rx_valid;
    logic          rx_done_tk;
    logic          frame_err;
    logic          overrun_err;

    receiver #(.over_sample(OS), .data_width(DW)) dut (
        .bclk        (bclk),
        .reset_n     (reset_n),
        .rx          (rx),
        .rx_ready    (rx_ready),
        .rx_dout     (rx_dout),
        .rx_valid    (rx_valid),
        .rx_done_tk  (rx_done_tk),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
    );

    always #5 bclk = ~bclk;

    typedef struct {
        int          cyc;
        logic [7:0]  data;
        bit          good;
    } ev_t;

    ev_t evq[$];
    int  cyc        = 0;
    int  n_cmp      = 0;
    int  n_bad      = 0;
    int  done_seen  = 0;
    int  done_exp   = 0;

    logic       m_valid = 1'b0;
    logic [7:0] m_dout  = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Per-cycle model of the frame outcome and holding register, compared 3 ns after each edge.
    always @(posedge bclk) begin : monitor
        logic rdy;
        logic e_done, e_ferr, e_oerr, load, consumed;
        ev_t  ev;
        cyc++;
        rdy = rx_ready;
        #3;
        e_done = 1'b0;
        e_ferr = 1'b0;
        e_oerr = 1'b0;
        if (!reset_n) begin
            evq.delete();
            m_valid = 1'b0;
            m_dout  = 8'h00;
        end else begin
            consumed = m_valid && rdy;
            load     = 1'b0;
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                ev = evq.pop_front();
                if (ev.good) begin
                    e_done = 1'b1;
                    done_exp++;
                    if (!m_valid || rdy) begin
                        load   = 1'b1;
                        m_dout = ev.data;
                    end else begin
                        e_oerr = 1'b1;
                    end
                end else begin
                    e_ferr = 1'b1;
                end
            end
            if (load) m_valid = 1'b1;
            else if (consumed) m_valid = 1'b0;
        end
        if (rx_done_tk) done_seen++;
        check($sformatf("cyc%0d done/ferr/oerr/valid/dout", cyc),
              {20'd0, rx_done_tk, frame_err, overrun_err, rx_valid, rx_dout},
              {20'd0, e_done, e_ferr, e_oerr, m_valid, m_dout});
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge bclk);
    endtask

    // Serialise one frame (start, 8 data LSB-first, stop), 16 cycles per bit.
    // rdy_at >= 0 raises rx_ready only on that drive cycle; rst_at >= 0 pulses reset.
    task automatic send_frame(input logic [7:0] d, input bit stop, input bit rand_rdy,
                              input int rdy_at, input int rst_at);
        logic [9:0] bits;
        ev_t        ev;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10 * OS; i++) begin
            @(negedge bclk);
            if (i == 0) begin
                ev.cyc  = cyc + STOP_LAT;
                ev.data = d;
                ev.good = stop;
                evq.push_back(ev);
            end
            rx = bits[i / OS];
            if (rand_rdy) rx_ready = 1'($urandom_range(0, 1));
            if (rdy_at >= 0) rx_ready = (i == rdy_at);
            if (rst_at >= 0) reset_n = !(i >= rst_at && i < rst_at + 3);
        end
        $display("frame data=%h stop=%0d sent at cyc %0d", d, stop, cyc);
    endtask

    initial begin
        logic [7:0] d;
        bit         stop;
        repeat (4) @(negedge bclk);
        reset_n = 1'b1;
        idle(5);

        // Plain frame, consumer always ready.
        rx_ready = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0, -1, -1);
        idle(20);

        // Short low glitch, then a real frame.
        rx = 1'b0;
        repeat (4) @(negedge bclk);
        idle(30);
        send_frame(8'h3C, 1'b1, 1'b0, -1, -1);
        idle(20);

        // Framing error followed by a long break, then a good frame.
        send_frame(8'h55, 1'b0, 1'b0, -1, -1);
        repeat (40) @(negedge bclk);
        idle(10);
        send_frame(8'h0F, 1'b1, 1'b0, -1, -1);
        idle(20);

        // Overrun: consumer stalled, two frames back-to-back.
        rx_ready = 1'b0;
        idle(2);
        send_frame(8'h11, 1'b1, 1'b0, -1, -1);
        send_frame(8'h22, 1'b1, 1'b0, -1, -1);
        idle(5);
        rx_ready = 1'b1;
        idle(3);

        // Drain coinciding with the stop sample: load must win, no overrun.
        rx_ready = 1'b0;
        send_frame(8'h42, 1'b1, 1'b0, -1, -1);
        idle(5);
        send_frame(8'h77, 1'b1, 1'b0, 10 * OS - 6, -1);
        idle(5);
        rx_ready = 1'b1;
        idle(3);

        // Reset mid-frame (bit 4), then a clean frame.
        send_frame(8'hFF, 1'b1, 1'b0, -1, 5 * OS);
        idle(10);
        send_frame(8'h81, 1'b1, 1'b0, -1, -1);
        idle(20);

        // Random frames with random consumer and occasional bad stop bits.
        for (int k = 0; k < 25; k++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            send_frame(d, stop, 1'b1, -1, -1);
            idle(stop ? int'($urandom_range(0, 12)) : int'($urandom_range(3, 12)));
        end
        rx_ready = 1'b1;
        idle(20);

        check("pending_events", 32'(evq.size()), 32'd0);
        check("done_pulse_count", 32'(done_seen), 32'(done_exp));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
